// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared bus widths and response-FSM state encoding for the SRAM responder.
//   ADDRBUS/DATABUS/DATADW : core address, data and byte-lane widths.
//   sram_st_e              : IDLE (nothing pending), RSP (data from macro), HOLD (data from hold register).
package sram_ctrl_pkg;
  localparam int ADDRBUS = 32;
  localparam int DATABUS = 32;
  localparam int DATADW  = 32;
  typedef enum logic [1:0] {
    SRAM_ST_IDLE = 2'd0,
    SRAM_ST_RSP  = 2'd1,
    SRAM_ST_HOLD = 2'd2
  } sram_st_e;
endpackage

// File: rtl/sram_1rw.sv
// sram_1rw: behavioural single-port synchronous SRAM, 1-cycle read latency, byte writes.
//   clk     : clock
//   ce_i    : chip enable; we_i selects write (1) or read (0)
//   addr_i  : word address
//   wdata_i : write data, wem_i : per-byte write enable
//   rdata_o : read data, valid the cycle after a read; holds otherwise
module sram_1rw #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            ce_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wem_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (ce_i && we_i) begin
      for (int b = 0; b < DW/8; b++)
        if (wem_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end else if (ce_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: responder for the SRAM cmd/rsp handshake, driving a 1-cycle-latency SRAM macro.
//   clk, rst (sync, active-low)
//   sram_cmd_*  : command channel from the arbiter (vld/rdy, byte addr, read, wdata, wmask)
//   sram_rsp_*  : in-order response channel (vld/rdy, err, rdata; rdata is 0 for writes/errors)
//   mem_*       : macro drive (ce, we, word addr, wdata, byte wem) and macro read data
// One response may be outstanding; a new command is taken the same cycle the
// pending response is consumed, so throughput is one per cycle.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                  MEM_AW    = 14,
  parameter logic [ADDRBUS-1:0]  BASE_ADDR = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sram_cmd_vld,
  output logic                sram_cmd_rdy,
  input  logic [ADDRBUS-1:0]  sram_cmd_addr,
  input  logic                sram_cmd_read,
  input  logic [DATABUS-1:0]  sram_cmd_wdata,
  input  logic [DATADW/8-1:0] sram_cmd_wmask,
  output logic                sram_rsp_vld,
  input  logic                sram_rsp_rdy,
  output logic                sram_rsp_err,
  output logic [DATABUS-1:0]  sram_rsp_rdata,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATABUS-1:0]  mem_wdata,
  output logic [DATADW/8-1:0] mem_wem,
  input  logic [DATABUS-1:0]  mem_rdata
);
  sram_st_e           state_q, state_d;
  logic               rd_q, err_q;
  logic [DATABUS-1:0] hold_q;
  logic               acc, bad;
  // Outside the window or not word-aligned: answered with an error, macro untouched.
  assign bad = (sram_cmd_addr[ADDRBUS-1:MEM_AW+2] != BASE_ADDR[ADDRBUS-1:MEM_AW+2])
             | (sram_cmd_addr[1:0] != 2'b00);
  assign acc = sram_cmd_vld & sram_cmd_rdy;
  always_ff @(posedge clk) begin
    if (!rst) state_q <= SRAM_ST_IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SRAM_ST_IDLE: state_d = acc ? SRAM_ST_RSP : SRAM_ST_IDLE;
      SRAM_ST_RSP:  state_d = sram_rsp_rdy ? (acc ? SRAM_ST_RSP : SRAM_ST_IDLE) : SRAM_ST_HOLD;
      SRAM_ST_HOLD: state_d = sram_rsp_rdy ? (acc ? SRAM_ST_RSP : SRAM_ST_IDLE) : SRAM_ST_HOLD;
      default:      state_d = SRAM_ST_IDLE;
    endcase
  end
  always_comb begin
    sram_cmd_rdy   = rst & ((state_q == SRAM_ST_IDLE) | sram_rsp_rdy);
    sram_rsp_vld   = (state_q != SRAM_ST_IDLE);
    sram_rsp_err   = err_q;
    sram_rsp_rdata = !rd_q ? '0 : (state_q == SRAM_ST_HOLD ? hold_q : mem_rdata);
    mem_ce         = acc & !bad;
    mem_we         = mem_ce & !sram_cmd_read;
    mem_addr       = sram_cmd_addr[MEM_AW+1:2];
    mem_wem        = sram_cmd_read ? '0 : sram_cmd_wmask;
    mem_wdata      = sram_cmd_wdata;
  end
  // The macro output is only valid for the cycle after the read, so a stalled
  // response snapshots it on the way into HOLD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q   <= 1'b0;
      err_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      if (acc) begin
        rd_q  <= sram_cmd_read & !bad;
        err_q <= bad;
      end
      if (state_q == SRAM_ST_RSP && !sram_rsp_rdy) hold_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized + directed bench for sram_ctrl against a transaction-level model.
module tb_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld, cmd_rdy, cmd_read, rsp_vld, rsp_rdy, rsp_err;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
  logic [3:0]  cmd_wmask, mem_wem;
  logic        mem_ce, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mac_rdata, mem_rdata, junk;
  logic        disturb;
  int          n_vec = 0, n_err = 0;
  logic [31:0] ref_mem [int];
  logic        pend = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_data = '0;
  int          age = 0;

  always #5 clk = ~clk;
  assign mem_rdata = disturb ? junk : mac_rdata;

  sram_ctrl #(.MEM_AW(14), .BASE_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .sram_cmd_vld(cmd_vld), .sram_cmd_rdy(cmd_rdy), .sram_cmd_addr(cmd_addr),
    .sram_cmd_read(cmd_read), .sram_cmd_wdata(cmd_wdata), .sram_cmd_wmask(cmd_wmask),
    .sram_rsp_vld(rsp_vld), .sram_rsp_rdy(rsp_rdy), .sram_rsp_err(rsp_err),
    .sram_rsp_rdata(rsp_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wem(mem_wem), .mem_rdata(mem_rdata)
  );
  sram_1rw #(.AW(14), .DW(32)) u_mem (
    .clk(clk), .ce_i(mem_ce), .we_i(mem_we), .addr_i(mem_addr),
    .wdata_i(mem_wdata), .wem_i(mem_wem), .rdata_o(mac_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic rs, input logic v, input logic rd, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] wm, input logic rr);
    logic e_rdy, e_acc, e_bad;
    int   w;
    rst = rs; cmd_vld = v; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
    rsp_rdy = rr; junk = $urandom;
    disturb = !(pend && age == 0) && ($urandom_range(1) == 1);
    e_bad = (a[31:16] != 16'h8000) || (a[1:0] != 2'b00);
    e_rdy = rs && (!pend || rr);
    e_acc = v && e_rdy;
    w     = int'(a[15:2]);
    @(negedge clk);
    check("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, e_rdy});
    check("rsp_vld", {31'd0, rsp_vld}, {31'd0, pend});
    if (pend) begin
      check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      check("rsp_rdata", rsp_rdata, exp_data);
    end
    check("mem_ce", {31'd0, mem_ce}, {31'd0, e_acc && !e_bad});
    if (e_acc && !e_bad) begin
      check("mem_we", {31'd0, mem_we}, {31'd0, !rd});
      check("mem_addr", {18'd0, mem_addr}, a[15:2] & 32'h3fff);
      if (!rd) check("mem_wem", {28'd0, mem_wem}, {28'd0, wm});
    end
    @(posedge clk);
    if (!rs) begin
      pend = 1'b0; age = 0;
    end else begin
      if (pend && rr) pend = 1'b0;
      else if (pend) age++;
      if (e_acc) begin
        pend = 1'b1; age = 0; exp_err = e_bad;
        exp_data = (rd && !e_bad) ? ref_mem[w] : 32'd0;
        if (!rd && !e_bad)
          for (int b = 0; b < 4; b++)
            if (wm[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; cmd_vld = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wmask = '0; rsp_rdy = 1'b1; disturb = 1'b0; junk = '0;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 0, 4'hf, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h8000_0000, 0, 4'hf, 1'b1);
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 32'h8000_0000 + 32'(i*4), $urandom, 4'hf, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hf, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'hFFFF_FFFF, 4'hf, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0010, 0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'h1122_3344, 4'b0101, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0020, 0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h8000_0020, 0, 4'h0, 1'b1);
    check("merged_word", ref_mem[8], 32'hFF22_FF44);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0010, 0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h8000_0004, 0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h8000_0004, 0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h9000_0000, 0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0002, 0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h8001_0000, 32'h5555_5555, 4'hf, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 32'h8000_0000 + 32'(i*4), 0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0010, 0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h8000_0010, 0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h8000_0010, 0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0010, 0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0010, 0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h8000_0010, 0, 4'h0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(9);
      a = 32'h8000_0000 + 32'($urandom_range(15) * 4);
      if (sel == 0) a = a | 32'h1000_0000;
      else if (sel == 1) a = a + 32'($urandom_range(3, 1));
      else if (sel == 2) a = a | 32'h0001_0000;
      step($urandom_range(49) != 0, $urandom_range(3) != 0, $urandom_range(1) == 1, a,
           $urandom, 4'($urandom), $urandom_range(2) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Responder end of the core's SRAM cmd/rsp handshake. Sits between `sram_arbt` (initiator) and a single-port synchronous SRAM macro (`sram_1rw`, 1-cycle read latency). It accepts one command per cycle, drives the macro, and returns exactly one in-order response per accepted command. When the initiator stalls the response, it holds read data stable, so the arbiter needs no hold logic of its own.

## Interface
Parameters:
- `MEM_AW`, 14: word-address width of the macro (16K words = 64 KiB).
- `BASE_ADDR`, 32'h8000_0000: byte base of the SRAM window. Aligned to 4·2^MEM_AW.

Ports (widths from `mydefines.v`: ADDRBUS = `MYRISCV_ADDRBUS`, DATABUS = `MYRISCV_DATABUS`, DW = `MYRISCV_DATADW`):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- sram_cmd_vld  in  1  command valid.
- sram_cmd_rdy  out  1  command ready.
- sram_cmd_addr  in  ADDRBUS  byte address.
- sram_cmd_read  in  1  1 = read, 0 = write.
- sram_cmd_wdata  in  DATABUS  write data.
- sram_cmd_wmask  in  DW/8  byte-enable for writes.
- sram_rsp_vld  out  1  response valid.
- sram_rsp_rdy  in  1  response ready.
- sram_rsp_err  out  1  response error.
- sram_rsp_rdata  out  DATABUS  read data; 0 for writes and errors.
- mem_ce  out  1  macro chip enable.
- mem_we  out  1  macro write enable.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  DATABUS  write data to the macro.
- mem_wem  out  DW/8  byte write-enable to the macro.
- mem_rdata  in  DATABUS  read data, valid the cycle after a `mem_ce` read.

## Operation
- Accept condition: `acc = sram_cmd_vld & sram_cmd_rdy`.
- Ready rule: `sram_cmd_rdy = rst & (state==IDLE | (state!=IDLE & sram_rsp_rdy))`.
  - This allows at most one outstanding response.
  - Throughput is 1 command per cycle while `sram_rsp_rdy` stays high.
- Error (`bad`) on an accepted command when either holds:
  - `addr[ADDRW-1:MEM_AW+2] != BASE_ADDR[ADDRW-1:MEM_AW+2]`, or
  - `addr[1:0] != 0`.
- Macro drive (combinational in the accept cycle):
  - `mem_ce = acc & !bad`
  - `mem_we = mem_ce & !sram_cmd_read`
  - `mem_addr = addr[MEM_AW+1:2]`
  - `mem_wem = sram_cmd_read ? 0 : wmask`
  - `mem_wdata = wdata`
- Registered on accept: `rd_r` (`read & !bad`) and `err_r` (`bad`).
- States:
  - IDLE: no response pending.
  - RSP: response pending; data comes straight from `mem_rdata`.
  - HOLD: response pending; data comes from the `hold_q` register.
- Transitions:
  - IDLE: `acc` → RSP.
  - RSP, `sram_rsp_rdy`: `acc` → RSP, else → IDLE.
  - RSP, `!sram_rsp_rdy`: → HOLD, and `hold_q <= mem_rdata`.
  - HOLD, `sram_rsp_rdy`: `acc` → RSP, else → IDLE.
  - HOLD, `!sram_rsp_rdy`: stay in HOLD.
- Outputs:
  - `sram_rsp_vld = (state != IDLE)`.
  - `sram_rsp_err = err_r`.
  - `sram_rsp_rdata = !rd_r ? 0 : (state==HOLD ? hold_q : mem_rdata)`.
- Writes and errors still produce exactly one response each.

## Timing
- Reset (rst = 0 at a clk edge):
  - state = IDLE, `rd_r = 0`, `err_r = 0`, `hold_q = 0`.
  - While rst is low: `sram_cmd_rdy = 0` and `mem_ce = 0`.
  - An outstanding response is dropped, never replayed.
- Latency: command accepted at edge k → `sram_rsp_vld` high during cycle k+1, combinationally.
- Handshake rules:
  - All response outputs stay stable while `vld & !rdy`.
  - `sram_rsp_vld` never deasserts without `sram_rsp_rdy`.
- Back-to-back: the response to command n and the acceptance of command n+1 complete on the same edge.
- Bubbles:
  - HOLD exit costs no bubble.
  - `sram_rsp_rdy` low for one cycle costs exactly one cycle.
- Writes: the macro is written at edge k. A read of the same address accepted at k+1 returns the new data.
- Simultaneous `acc` with response completion: `rd_r`/`err_r` update to the new command, and state stays RSP.

## Structure
- Shared package/header (`mydefines.v`):
  - `MYRISCV_ADDRBUS`, `MYRISCV_DATABUS`, `MYRISCV_DATADW`.
  - New state constants `SRAM_ST_IDLE/RSP/HOLD` (2 bits).
- No sub-module inside the block.
- `sram_1rw` (behavioural macro, 1-cycle read, byte-write) is a sibling instantiated by the parent. The bench uses the same model.

## Test plan
- Read at 0x8000_0010 holding 0xDEADBEEF, `rsp_rdy = 1` → `mem_ce` in the accept cycle; next cycle `rsp_vld = 1`, `rdata = 0xDEADBEEF`, `err = 0`.
- Write 0x1122_3344 with mask 4'b0101 to 0x8000_0020 (old 0xFFFF_FFFF), then an immediate read → `rsp_rdata = 0xFF22_FF44`; the write response has `rdata = 0`.
- Read with `rsp_rdy` held low for 3 cycles while `mem_rdata` is disturbed → `rdata` stable at the original value; `cmd_rdy = 0` throughout; completes on the first cycle `rdy = 1`.
- Address 0x9000_0000 or 0x8000_0002 → `mem_ce = 0`, `rsp_err = 1`, `rdata = 0`.
- 8 back-to-back reads with `rsp_rdy = 1` → 8 responses on 8 consecutive cycles, in order.
- Assert rst low while in HOLD → the next cycle has `rsp_vld = 0` and `cmd_rdy = 0`; after release, `cmd_rdy = 1` and there is no stale response.
